// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the DHT11 command executor:
//   - request codes accepted on cmd_code
//   - response codes returned on rsp_code
//   - FSM state encoding
//   - checksum helper for the DHT11 5-byte frame
// -----------------------------------------------------------------------------
package sensor_pkg;

  // Request codes
  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_TEMP   = 8'h01;
  localparam logic [7:0] CMD_HUM    = 8'h02;

  // Response codes
  localparam logic [7:0] RSP_STATUS_OK  = 8'h07;
  localparam logic [7:0] RSP_TEMP_OK    = 8'h08;
  localparam logic [7:0] RSP_HUM_OK     = 8'h09;
  localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;
  localparam logic [7:0] RSP_BAD_CMD    = 8'hCF;
  localparam logic [7:0] RSP_CSUM_ERR   = 8'hEF;

  // FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_CHECK     = 3'd5,
    ST_RESP      = 3'd6
  } state_e;

  // DHT11 checksum: byte-wise sum of the four data fields, modulo 256.
  function automatic logic [7:0] dht_checksum(
    input logic [7:0] h_int,
    input logic [7:0] h_frac,
    input logic [7:0] t_int,
    input logic [7:0] t_frac
  );
    dht_checksum = h_int + h_frac + t_int + t_frac;
  endfunction

endpackage

// File: rtl/sensor_cmd_exec_interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count -> 0)
//   clear : synchronous clear, wins over en
//   en    : count enable
//   done  : high when the count has reached LIMIT, or reaches it on this edge
// done looks one edge ahead so a controller sampling it makes its move on the
// same edge at which the count arrives at LIMIT.
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int unsigned LIMIT = 32'd100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int unsigned W = (LIMIT > 32'd0) ? $clog2(LIMIT + 32'd1) : 32'd1;
  localparam logic [W-1:0] LIMIT_C = W'(LIMIT);
  localparam logic [W-1:0] LAST_C  = W'(LIMIT - 32'd1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise count up and hold at LIMIT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT_C)) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == LIMIT_C) || (en && (count_q == LAST_C));

endmodule

// File: rtl/sensor_cmd_exec.sv
// -----------------------------------------------------------------------------
// sensor_cmd_exec
// Executes one-at-a-time requests against a DHT11 reader and returns a single
// response per request.
// Ports:
//   clk_50MHz, rst            : clock and asynchronous active-high reset
//   cmd_valid/cmd_ready       : request handshake, cmd_code selects the read
//   rsp_valid/rsp_ready       : response handshake, rsp_code/rsp_data payload
//   dht_en, dht_rst           : reader enable and reader start/reset pulse
//   dht_wai, dht_error        : reader busy and reader transmission error
//   hum_int..temp_float, cs   : reader result frame
// Sensor reads are spaced at least GAP_CYCLES apart (measured from the end of
// the previous read, and from reset) and abort after TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module sensor_cmd_exec
  import sensor_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 32'd100000000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd5000000
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_code,
  output logic [7:0] rsp_data,
  output logic       dht_en,
  output logic       dht_rst,
  input  logic       dht_wai,
  input  logic       dht_error,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic [7:0] cs
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic       fail_q, fail_d;
  logic [7:0] rsp_code_q, rsp_code_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       dht_en_q, dht_en_d;
  logic       dht_rst_q, dht_rst_d;

  logic gap_clear, gap_done;
  logic tmo_clear, tmo_en, tmo_done;

  // The gap timer runs freely and restarts when a read finishes, so the next
  // START is held off until GAP_CYCLES after the previous CHECK.
  assign gap_clear = (state_d == ST_CHECK) && (state_q != ST_CHECK);

  // The read window is cleared as START is entered and counts the START cycle
  // plus both wait states, so a read occupies at most TIMEOUT_CYCLES clocks
  // with dht_en high before CHECK is forced.
  assign tmo_clear = (state_d == ST_START) && (state_q != ST_START);
  assign tmo_en    = (state_q == ST_START) || (state_q == ST_WAIT_BUSY) ||
                     (state_q == ST_WAIT_DONE);

  interval_timer #(.LIMIT(GAP_CYCLES)) u_gap_timer (
    .clk   (clk_50MHz),
    .rst   (rst),
    .clear (gap_clear),
    .en    (1'b1),
    .done  (gap_done)
  );

  interval_timer #(.LIMIT(TIMEOUT_CYCLES)) u_tmo_timer (
    .clk   (clk_50MHz),
    .rst   (rst),
    .clear (tmo_clear),
    .en    (tmo_en),
    .done  (tmo_done)
  );

  // Next-state, latched request, response payload and registered output values.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    fail_d     = fail_q;
    rsp_code_d = rsp_code_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_code > CMD_HUM) begin
            state_d    = ST_RESP;
            rsp_code_d = RSP_BAD_CMD;
            rsp_data_d = 8'h00;
          end else begin
            cmd_d   = cmd_code;
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_START;
        end else begin
          state_d = ST_GAP;
        end
      end

      ST_START: begin
        fail_d  = 1'b0;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (tmo_done) begin
          fail_d  = 1'b1;
          state_d = ST_CHECK;
        end else if (dht_wai) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end

      ST_WAIT_DONE: begin
        // dht_error may be a single-cycle pulse, so it is captured here rather
        // than re-sampled in CHECK.
        if (tmo_done || dht_error) begin
          fail_d  = 1'b1;
          state_d = ST_CHECK;
        end else if (!dht_wai) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_CHECK: begin
        state_d = ST_RESP;
        if (fail_q) begin
          rsp_code_d = RSP_SENSOR_ERR;
          rsp_data_d = 8'h00;
        end else if (dht_checksum(hum_int, hum_float, temp_int, temp_float) != cs) begin
          rsp_code_d = RSP_CSUM_ERR;
          rsp_data_d = 8'h00;
        end else begin
          case (cmd_q)
            CMD_STATUS: begin
              rsp_code_d = RSP_STATUS_OK;
              rsp_data_d = 8'h00;
            end
            CMD_TEMP: begin
              rsp_code_d = RSP_TEMP_OK;
              rsp_data_d = temp_int;
            end
            CMD_HUM: begin
              rsp_code_d = RSP_HUM_OK;
              rsp_data_d = hum_int;
            end
            default: begin
              rsp_code_d = RSP_BAD_CMD;
              rsp_data_d = 8'h00;
            end
          endcase
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    dht_en_d    = (state_d == ST_START) || (state_d == ST_WAIT_BUSY) ||
                  (state_d == ST_WAIT_DONE);
    dht_rst_d   = (state_d == ST_START);
  end

  // State, request and output registers.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      fail_q      <= 1'b0;
      rsp_code_q  <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      dht_en_q    <= 1'b0;
      dht_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      fail_q      <= fail_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      dht_en_q    <= dht_en_d;
      dht_rst_q   <= dht_rst_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_data  = rsp_data_q;
  assign dht_en    = dht_en_q;
  assign dht_rst   = dht_rst_q;

endmodule

// File: tb/tb_sensor_cmd_exec.sv
// -----------------------------------------------------------------------------
// tb_sensor_cmd_exec
// Directed scenarios plus randomized reads against a DHT11 behavioural model.
// Expected responses come from ref_rsp(), which applies the response rules
// directly to the request and the frame the model presents.
// -----------------------------------------------------------------------------
module tb_sensor_cmd_exec;

  localparam int GAP = 100;
  localparam int TMO = 50;

  localparam int M_NORM   = 0;
  localparam int M_NOBUSY = 1;
  localparam int M_ERR    = 2;
  localparam int M_HOLD   = 3;

  logic       clk_50MHz = 1'b0;
  logic       rst       = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code  = 8'h00;
  logic       rsp_ready = 1'b0;
  logic       dht_wai   = 1'b0;
  logic       dht_error = 1'b0;
  logic [7:0] hum_int   = 8'h00;
  logic [7:0] hum_float = 8'h00;
  logic [7:0] temp_int  = 8'h00;
  logic [7:0] temp_float = 8'h00;
  logic [7:0] cs        = 8'h00;

  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_code;
  logic [7:0] rsp_data;
  logic       dht_en;
  logic       dht_rst;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mode = M_NORM;
  int start_cyc = 0;
  int starts = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = 0;
  int rel_cyc = 0;
  int chk_cyc = 0;

  sensor_cmd_exec #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_code   (rsp_code),
    .rsp_data   (rsp_data),
    .dht_en     (dht_en),
    .dht_rst    (dht_rst),
    .dht_wai    (dht_wai),
    .dht_error  (dht_error),
    .hum_int    (hum_int),
    .hum_float  (hum_float),
    .temp_int   (temp_int),
    .temp_float (temp_float),
    .cs         (cs)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference response: {code, data} from the request and the sensor outcome.
  function automatic logic [15:0] ref_rsp(input int code, input bit fail,
                                          input int hi, input int hf,
                                          input int ti, input int tf, input int c);
    int sum;
    sum = (hi + hf + ti + tf) % 256;
    if (code > 2)       return 16'hCF00;
    else if (fail)      return 16'h1F00;
    else if (sum != c)  return 16'hEF00;
    else if (code == 0) return 16'h0700;
    else if (code == 1) return {8'h08, 8'(ti)};
    else                return {8'h09, 8'(hi)};
  endfunction

  task automatic set_frame(input logic [7:0] hi, input logic [7:0] hf,
                           input logic [7:0] ti, input logic [7:0] tf,
                           input logic [7:0] c);
    hum_int = hi; hum_float = hf; temp_int = ti; temp_float = tf; cs = c;
  endtask

  task automatic do_cmd(input logic [7:0] code);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk_50MHz);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    cmd_valid = 1'b1;
    cmd_code = code;
    @(negedge clk_50MHz);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [15:0] exp, input int hold);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 1000) begin
      @(negedge clk_50MHz);
      n++;
    end
    last_rsp_cyc = cyc;
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    chk("rsp_code", 32'(rsp_code), 32'(exp[15:8]));
    chk("rsp_data", 32'(rsp_data), 32'(exp[7:0]));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_50MHz);
      chk("rsp_hold_stable", 32'({rsp_valid, rsp_code, rsp_data}), 32'({1'b1, exp}));
    end
    rsp_ready = 1'b1;
    @(negedge clk_50MHz);
    rsp_ready = 1'b0;
    chk("rsp_done_idle", 32'({rsp_valid, cmd_ready}), 32'd1);
  endtask

  // DHT11 reader model: reacts to each dht_rst pulse according to mode.
  initial begin
    forever begin
      @(negedge clk_50MHz);
      if (dht_rst === 1'b1) begin
        start_cyc = cyc;
        starts++;
        if (mode == M_NORM || mode == M_ERR) begin
          repeat ($urandom_range(1, 8)) @(negedge clk_50MHz);
          dht_wai = 1'b1;
          repeat ($urandom_range(3, 15)) @(negedge clk_50MHz);
          if (mode == M_ERR) begin
            dht_error = 1'b1;
            @(negedge clk_50MHz);
            dht_error = 1'b0;
            repeat (2) @(negedge clk_50MHz);
          end
          dht_wai = 1'b0;
        end else if (mode == M_HOLD) begin
          repeat (3) @(negedge clk_50MHz);
          dht_wai = 1'b1;
          repeat (40) @(negedge clk_50MHz);
          dht_wai = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    int n0;
    int code;
    int pick;
    int hi, hf, ti, tf, c;
    logic [15:0] exp;

    // Reset values while rst is held
    repeat (3) @(negedge clk_50MHz);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_code",  32'(rsp_code),  32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_dht_en",    32'(dht_en),    32'd0);
    chk("rst_dht_rst",   32'(dht_rst),   32'd0);
    rst = 1'b0;
    rel_cyc = cyc;

    // Temperature read straight after reset must wait out the power-up gap
    mode = M_NORM;
    set_frame(8'h28, 8'h00, 8'h19, 8'h00, 8'h41);
    do_cmd(8'h01);
    get_rsp(16'h0819, 0);
    chk("first_start_after_gap", 32'((start_cyc - rel_cyc) >= GAP), 32'd1);
    chk_cyc = last_rsp_cyc - 1;

    // Back-to-back humidity read, gap measured from the previous CHECK
    do_cmd(8'h02);
    get_rsp(16'h0928, 0);
    chk("b2b_start_after_gap", 32'((start_cyc - chk_cyc) >= GAP), 32'd1);

    // Checksum mismatch; requests offered during the read are ignored
    set_frame(8'h28, 8'h00, 8'h19, 8'h00, 8'h42);
    do_cmd(8'h00);
    cmd_valid = 1'b1;
    cmd_code = 8'h05;
    for (int k = 0; k < 5; k++) begin
      chk("busy_not_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk_50MHz);
    end
    cmd_valid = 1'b0;
    get_rsp(16'hEF00, 0);

    // Reader never goes busy: CHECK 50 cycles after START, RESP one later
    set_frame(8'h28, 8'h00, 8'h19, 8'h00, 8'h41);
    mode = M_NOBUSY;
    do_cmd(8'h01);
    get_rsp(16'h1F00, 0);
    chk("timeout_latency", 32'(last_rsp_cyc - start_cyc), 32'(TMO + 1));

    // Error pulse while waiting for completion
    mode = M_ERR;
    do_cmd(8'h02);
    get_rsp(16'h1F00, 0);

    // Unknown code: immediate response, no sensor access, stable while stalled
    mode = M_NORM;
    n0 = starts;
    do_cmd(8'h05);
    get_rsp(16'hCF00, 10);
    chk("bad_cmd_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);
    chk("bad_cmd_no_start", 32'(starts), 32'(n0));

    // Randomized reads checked against the reference model
    for (int i = 0; i < 6; i++) begin
      code = int'($urandom_range(0, 4));
      pick = int'($urandom_range(0, 5));
      mode = (pick == 0) ? M_ERR : ((pick == 1) ? M_NOBUSY : M_NORM);
      hi = int'($urandom_range(0, 255));
      hf = int'($urandom_range(0, 255));
      ti = int'($urandom_range(0, 255));
      tf = int'($urandom_range(0, 255));
      c  = (hi + hf + ti + tf) % 256;
      if ($urandom_range(0, 3) == 0) c = (c + int'($urandom_range(1, 255))) % 256;
      set_frame(8'(hi), 8'(hf), 8'(ti), 8'(tf), 8'(c));
      exp = ref_rsp(code, mode != M_NORM, hi, hf, ti, tf, c);
      do_cmd(8'(code));
      get_rsp(exp, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of WAIT_DONE
    mode = M_HOLD;
    do_cmd(8'h01);
    n = 0;
    while (dht_wai !== 1'b1 && n < 400) begin
      @(negedge clk_50MHz);
      n++;
    end
    chk("hold_reader_busy", 32'(dht_wai), 32'd1);
    repeat (2) @(negedge clk_50MHz);
    chk("hold_dht_en", 32'(dht_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_code",  32'(rsp_code),  32'd0);
    chk("midrst_rsp_data",  32'(rsp_data),  32'd0);
    chk("midrst_dht_en",    32'(dht_en),    32'd0);
    chk("midrst_dht_rst",   32'(dht_rst),   32'd0);
    @(negedge clk_50MHz);
    rst = 1'b0;
    n0 = starts;
    n = 0;
    repeat (150) begin
      @(negedge clk_50MHz);
      if (rsp_valid === 1'b1 || dht_en === 1'b1) n++;
    end
    chk("postrst_quiet", 32'(n), 32'd0);
    chk("postrst_no_start", 32'(starts), 32'(n0));
    chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
